// File: rtl/bc_score_sequencer.sv
// Bulls & Cows scoring controller: distinct-digit check, serial scoring,
// turn alternation, per-player turn counts and winner latch.
//
// Ports:
//   clock, reset (async, active-low), clear (sync new-game clear)
//   start/player/guess      : scoring request from the game FSM
//   secret_p1/secret_p2     : player secrets (each scores the other's guess)
//   busy/done/wrong_turn    : handshake and rejection pulse
//   invalid/bulls/cows      : result of the last request
//   next_player/win/winner  : turn and game state
//   turns_p1/turns_p2       : saturating valid-guess counts
module bc_score_sequencer #(
    parameter int DIGITS    = 4,
    parameter int DW        = 4,
    parameter int MAX_TURNS = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 player,
    input  logic [DIGITS*DW-1:0] guess,
    input  logic [DIGITS*DW-1:0] secret_p1,
    input  logic [DIGITS*DW-1:0] secret_p2,
    output logic                 busy,
    output logic                 done,
    output logic                 invalid,
    output logic                 wrong_turn,
    output logic [2:0]           bulls,
    output logic [2:0]           cows,
    output logic                 next_player,
    output logic                 win,
    output logic                 winner,
    output logic [3:0]           turns_p1,
    output logic [3:0]           turns_p2
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCORE,
        REPORT
    } state_t;

    state_t state, state_n;

    logic [DIGITS*DW-1:0] g_reg;
    logic [DIGITS*DW-1:0] s_reg;
    logic                 p_reg;
    logic [IW-1:0]        idx;
    logic [2:0]           bacc;
    logic [2:0]           cacc;

    logic [DW-1:0] g_d [DIGITS];
    logic [DW-1:0] s_d [DIGITS];
    logic [IW-1:0] pos;
    logic [DW-1:0] g_dig;
    logic          hit;
    logic          cow_hit;
    logic          dup;
    logic          accept;
    logic          last;
    logic [2:0]    bull_sum;
    logic [2:0]    cow_sum;

    assign busy = (state != IDLE);
    assign done = (state == REPORT);

    always_comb begin
        state_n  = state;
        hit      = 1'b0;
        cow_hit  = 1'b0;
        dup      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            g_d[i] = g_reg[i*DW +: DW];
            s_d[i] = s_reg[i*DW +: DW];
        end
        // idx walks digits MSB-first
        pos   = IW'(DIGITS - 1) - idx;
        g_dig = g_d[pos];
        hit   = (g_dig == s_d[pos]);
        for (int j = 0; j < DIGITS; j++) begin
            if ((IW'(j) != pos) && (s_d[j] == g_dig)) begin
                cow_hit = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (g_d[i] == g_d[j]) begin
                    dup = 1'b1;
                end
            end
        end
        bull_sum = bacc + {2'b00, hit};
        cow_sum  = cacc + {2'b00, (!hit && cow_hit)};
        last     = (idx == IW'(DIGITS - 1));
        accept   = start && (player == next_player) && !win;

        unique case (state)
            IDLE:   if (accept) state_n = CHECK;
            CHECK:  state_n = dup ? REPORT : SCORE;
            SCORE:  if (last) state_n = REPORT;
            REPORT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            g_reg       <= '0;
            s_reg       <= '0;
            p_reg       <= 1'b0;
            idx         <= '0;
            bacc        <= '0;
            cacc        <= '0;
            invalid     <= 1'b0;
            wrong_turn  <= 1'b0;
            bulls       <= '0;
            cows        <= '0;
            next_player <= 1'b0;
            win         <= 1'b0;
            winner      <= 1'b0;
            turns_p1    <= '0;
            turns_p2    <= '0;
        end else if (clear) begin
            state       <= IDLE;
            idx         <= '0;
            bacc        <= '0;
            cacc        <= '0;
            invalid     <= 1'b0;
            wrong_turn  <= 1'b0;
            bulls       <= '0;
            cows        <= '0;
            next_player <= 1'b0;
            win         <= 1'b0;
            winner      <= 1'b0;
            turns_p1    <= '0;
            turns_p2    <= '0;
        end else begin
            state      <= state_n;
            wrong_turn <= (state == IDLE) && start && !accept;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        g_reg <= guess;
                        s_reg <= player ? secret_p1 : secret_p2;
                        p_reg <= player;
                        idx   <= '0;
                        bacc  <= '0;
                        cacc  <= '0;
                    end
                end
                CHECK: begin
                    // results are loaded on entry to REPORT so they are
                    // already valid in the done cycle
                    if (dup) begin
                        invalid <= 1'b1;
                        bulls   <= '0;
                        cows    <= '0;
                    end
                end
                SCORE: begin
                    bacc <= bull_sum;
                    cacc <= cow_sum;
                    idx  <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        invalid <= 1'b0;
                        bulls   <= bull_sum;
                        cows    <= cow_sum;
                        if (p_reg) begin
                            if (turns_p2 != 4'(MAX_TURNS))
                                turns_p2 <= turns_p2 + 4'd1;
                        end else begin
                            if (turns_p1 != 4'(MAX_TURNS))
                                turns_p1 <= turns_p1 + 4'd1;
                        end
                        if (bull_sum == 3'(DIGITS)) begin
                            win    <= 1'b1;
                            winner <= p_reg;
                        end else begin
                            next_player <= ~p_reg;
                        end
                    end
                end
                REPORT: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
